// File: rtl/seq_shifter.sv
// Multi-cycle barrel shifter: shifts by at most STEP bits per clock until shamt is consumed.
// Optional rotate-right on op=11 is enabled by defining SEQ_SHIFTER_ROTATE_EN.
module seq_shifter #(
    parameter int unsigned NUM_SIZE = 32,
    parameter int unsigned STEP     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  op,
    input  logic [$clog2(NUM_SIZE)-1:0] shamt,
    input  logic [NUM_SIZE-1:0]         dIn0,
    output logic [NUM_SIZE-1:0]         dOut,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned W = $clog2(NUM_SIZE);
    // One extra bit so STEP == NUM_SIZE is still representable.
    localparam logic [W:0] STEP_W = (W+1)'(STEP);
`ifdef SEQ_SHIFTER_ROTATE_EN
    localparam logic [W:0] NUM_W  = (W+1)'(NUM_SIZE);
`endif

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [NUM_SIZE-1:0] r_work;
    logic [NUM_SIZE-1:0] r_dout;
    logic [W-1:0]        r_rem;
    logic [1:0]          r_op;
    logic [W:0]          w_s;
    logic [W-1:0]        w_rem_next;
    logic [NUM_SIZE-1:0] w_shifted;

    // s = min(remaining, STEP); s never exceeds remaining, so the low W bits suffice below.
    assign w_s        = ({1'b0, r_rem} >= STEP_W) ? STEP_W : {1'b0, r_rem};
    assign w_rem_next = r_rem - w_s[W-1:0];

    always_comb begin
        w_shifted = r_work >> w_s;
        case (r_op)
            2'b00:   w_shifted = r_work << w_s;
            2'b10:   w_shifted = $signed(r_work) >>> w_s;
`ifdef SEQ_SHIFTER_ROTATE_EN
            2'b11:   w_shifted = (r_work >> w_s) | (r_work << (NUM_W - w_s));
`endif
            default: w_shifted = r_work >> w_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (start) w_state_next = StShift;
            StShift: if (w_rem_next == '0) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= '0;
            r_rem  <= '0;
            r_op   <= '0;
            r_dout <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_work <= dIn0;
                        r_rem  <= shamt;
                        r_op   <= op;
                    end
                end
                StShift: begin
                    r_work <= w_shifted;
                    r_rem  <= w_rem_next;
                    if (w_rem_next == '0) r_dout <= w_shifted;
                end
                default: ;
            endcase
        end
    end

    assign dOut = r_dout;
    assign busy = (r_state == StShift);
    assign done = (r_state == StDone);

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter (NUM_SIZE=32, STEP=4) against a one-step shift model.
// Define SEQ_SHIFTER_ROTATE_EN for both bench and RTL to check the rotate variant.
module tb_seq_shifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] dIn0;
    logic [31:0] dOut;
    logic        busy;
    logic        done;

    int total;
    int bad;

    seq_shifter #(
        .NUM_SIZE(32),
        .STEP    (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .shamt(shamt),
        .dIn0 (dIn0),
        .dOut (dOut),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input int sh,
                                              input logic [31:0] d);
        logic signed [31:0] sd;
        sd = d;
        case (o)
            2'b00: return d << sh;
            2'b01: return d >> sh;
            2'b10: return sd >>> sh;
            default: begin
`ifdef SEQ_SHIFTER_ROTATE_EN
                if (sh == 0) return d;
                return (d >> sh) | (d << (32 - sh));
`else
                return d >> sh;
`endif
            end
        endcase
    endfunction

    function automatic int ref_lat(input int sh);
        return (sh == 0) ? 1 : (sh + 3) / 4;
    endfunction

    // Runs one operation; reports done latency (edges after accept), busy cycles, done pulses,
    // the result at done and the dOut value seen just after the accept edge.
    task automatic do_op(input logic [1:0] o, input logic [4:0] sh, input logic [31:0] d,
                         input bit hold, output int lat, output int bcnt, output int dcnt,
                         output logic [31:0] res, output logic [31:0] mid);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        shamt = sh;
        dIn0  = d;
        @(posedge clk);
        #1;
        mid  = dOut;
        lat  = -1;
        bcnt = busy ? 1 : 0;
        dcnt = done ? 1 : 0;
        res  = 'x;
        if (hold) begin
            dIn0  = 32'hFFFF_FFFF;
            shamt = 5'd0;
        end else begin
            start = 1'b0;
        end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat < 0) begin
                    lat   = k;
                    res   = dOut;
                    start = 1'b0;
                end
            end
            if (lat >= 0 && k >= lat + 3) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        shamt = 5'd0;
        dIn0  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dOut !== 32'h0) begin
            bad++;
            $display("FAIL reset_dout got=%h want=00000000", dOut);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL reset_done got=%b want=0", done);
        end
        rst = 1'b0;
    endtask

    task automatic test_sra_worst();
        int lat, bcnt, dcnt;
        logic [31:0] res, mid;
        do_op(2'b10, 5'd31, 32'h8000_0000, 1'b0, lat, bcnt, dcnt, res, mid);
        total++;
        if (res !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL sra_worst_result got=%h want=ffffffff", res);
        end
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL sra_worst_latency got=%0d want=8", lat);
        end
        total++;
        if (bcnt !== 8) begin
            bad++;
            $display("FAIL sra_worst_busy_cycles got=%0d want=8", bcnt);
        end
        total++;
        if (dcnt !== 1) begin
            bad++;
            $display("FAIL sra_worst_done_pulses got=%0d want=1", dcnt);
        end
    endtask

    task automatic test_short_ops();
        int lat, bcnt, dcnt;
        logic [31:0] res, mid;
        do_op(2'b00, 5'd0, 32'h0000_0001, 1'b0, lat, bcnt, dcnt, res, mid);
        total++;
        if (res !== 32'h0000_0001) begin
            bad++;
            $display("FAIL sll0_result got=%h want=00000001", res);
        end
        total++;
        if (lat !== 1 || bcnt !== 1) begin
            bad++;
            $display("FAIL sll0_timing got=lat%0d/busy%0d want=lat1/busy1", lat, bcnt);
        end
        do_op(2'b01, 5'd4, 32'hF000_0000, 1'b0, lat, bcnt, dcnt, res, mid);
        total++;
        if (res !== 32'h0F00_0000) begin
            bad++;
            $display("FAIL srl4_result got=%h want=0f000000", res);
        end
        total++;
        if (lat !== 1 || bcnt !== 1) begin
            bad++;
            $display("FAIL srl4_timing got=lat%0d/busy%0d want=lat1/busy1", lat, bcnt);
        end
    endtask

    task automatic test_ror();
        int lat, bcnt, dcnt;
        logic [31:0] res, mid, want;
`ifdef SEQ_SHIFTER_ROTATE_EN
        want = 32'h8000_0000;
`else
        want = 32'h0000_0000;
`endif
        do_op(2'b11, 5'd1, 32'h0000_0001, 1'b0, lat, bcnt, dcnt, res, mid);
        total++;
        if (res !== want) begin
            bad++;
            $display("FAIL ror1_result got=%h want=%h", res, want);
        end
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL ror1_latency got=%0d want=1", lat);
        end
    endtask

    task automatic test_start_ignored();
        int lat, bcnt, dcnt;
        logic [31:0] res, mid;
        do_op(2'b00, 5'd9, 32'h0000_000F, 1'b1, lat, bcnt, dcnt, res, mid);
        total++;
        if (res !== 32'h0000_1E00) begin
            bad++;
            $display("FAIL held_start_result got=%h want=00001e00", res);
        end
        total++;
        if (dcnt !== 1) begin
            bad++;
            $display("FAIL held_start_done_pulses got=%0d want=1", dcnt);
        end
        total++;
        if (lat !== 3 || bcnt !== 3) begin
            bad++;
            $display("FAIL held_start_timing got=lat%0d/busy%0d want=lat3/busy3", lat, bcnt);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bcnt, dcnt, abort_dones;
        logic [31:0] res, mid;
        abort_dones = 0;
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        shamt = 5'd20;
        dIn0  = $urandom;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) abort_dones++;
        end
        // Start is held alongside rst to show reset wins.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (done) abort_dones++;
        total++;
        if (dOut !== 32'h0) begin
            bad++;
            $display("FAIL abort_dout got=%h want=00000000", dOut);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_busy got=%b want=0", busy);
        end
        total++;
        if (abort_dones !== 0) begin
            bad++;
            $display("FAIL abort_done_pulses got=%0d want=0", abort_dones);
        end
        rst   = 1'b0;
        start = 1'b0;
        do_op(2'b01, 5'd8, 32'h1234_5678, 1'b0, lat, bcnt, dcnt, res, mid);
        total++;
        if (res !== 32'h0012_3456) begin
            bad++;
            $display("FAIL post_abort_result got=%h want=00123456", res);
        end
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL post_abort_latency got=%0d want=2", lat);
        end
    endtask

    task automatic test_random();
        int lat, bcnt, dcnt, sh;
        logic [1:0] o;
        logic [31:0] d, res, mid, want, prev;
        prev = 32'h0012_3456;
        for (int n = 0; n < 1000; n++) begin
            o    = 2'($urandom_range(0, 3));
            sh   = $urandom_range(0, 31);
            d    = $urandom;
            want = ref_shift(o, sh, d);
            do_op(o, 5'(sh), d, 1'b0, lat, bcnt, dcnt, res, mid);
            total++;
            if (res !== want) begin
                bad++;
                $display("FAIL rand_result op=%0d sh=%0d d=%h got=%h want=%h",
                         o, sh, d, res, want);
            end
            total++;
            if (lat !== ref_lat(sh) || bcnt !== ref_lat(sh) || dcnt !== 1) begin
                bad++;
                $display("FAIL rand_timing sh=%0d got=lat%0d/busy%0d/done%0d want=lat%0d/1",
                         sh, lat, bcnt, dcnt, ref_lat(sh));
            end
            total++;
            if (mid !== prev) begin
                bad++;
                $display("FAIL rand_dout_hold got=%h want=%h", mid, prev);
            end
            prev = want;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sra_worst();
        test_short_ops();
        test_ror();
        test_start_ignored();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
